// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide scheduler that owns the architectural HI/LO pair.
// Results are computed at issue, held pending, and committed after a fixed latency.
module muldiv_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic [4:0]  busy_cnt,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_valid;

  logic        is_md_op;
  logic        is_div;
  logic [4:0]  cnt_nxt;
  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_valid;

  assign is_md_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign start    = is_md_op & ~busy;
  assign stall_md = d_is_md & (start | busy);

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign a_sx    = {{32{src_a[31]}}, src_a};
  assign b_sx    = {{32{src_b[31]}}, src_b};
  assign prod_s  = a_sx * b_sx;
  assign prod_u  = {32'd0, src_a} * {32'd0, src_b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign divisor = (src_b == 32'd0) ? 32'd1 : src_b;
  assign quot_s  = $signed(src_a) / $signed(divisor);
  assign rem_s   = $signed(src_a) % $signed(divisor);
  assign quot_u  = src_a / divisor;
  assign rem_u   = src_a % divisor;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    res_hi    = prod_u[63:32];
    res_lo    = prod_u[31:0];
    res_valid = 1'b1;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_DIV: begin
        res_hi    = rem_s;
        res_lo    = quot_s;
        res_valid = (src_b != 32'd0);
      end
      OP_DIVU: begin
        res_hi    = rem_u;
        res_lo    = quot_u;
        res_valid = (src_b != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = busy_cnt;
    if (busy) begin
      cnt_nxt = busy_cnt - 5'd1;
    end else if (start) begin
      cnt_nxt = is_div ? DIV_CNT : MULT_CNT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt      <= '0;
      busy          <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      // NOTE: the pending result is cleared too, so a reset mid-operation can never commit it.
      pending_hi    <= '0;
      pending_lo    <= '0;
      pending_valid <= 1'b0;
    end else begin
      busy_cnt <= cnt_nxt;
      busy     <= (cnt_nxt != 5'd0);
      if (busy) begin
        if (busy_cnt == 5'd1 && pending_valid) begin
          hi <= pending_hi;
          lo <= pending_lo;
        end
      end else if (start) begin
        pending_hi    <= res_hi;
        pending_lo    <= res_lo;
        pending_valid <= res_valid;
      end else if (op == OP_MTHI) begin
        hi <= src_a;
      end else if (op == OP_MTLO) begin
        lo <= src_a;
      end
    end
  end

endmodule
